// File: rtl/sram_read_seq_if.sv
// Read-port bundle for the SRAM read sequencer: client handshake plus the
// array-side precharge, wordline, sense and bitline signals.
interface sram_read_seq_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic                   rd_req;
   logic [ADDR_W-1:0]      rd_addr;
   logic                   rd_busy;
   logic                   pre_n;
   logic [2**ADDR_W-1:0]   wl;
   logic                   sae;
   logic [DATA_W-1:0]      bl;
   logic [DATA_W-1:0]      blb;
   logic [DATA_W-1:0]      rd_data;
   logic                   rd_err;
   logic                   rd_valid;
   logic                   rd_rdy;

   // Handshake: a word transfers on the rising edge where rd_valid and rd_rdy
   // are both high; once raised, rd_valid, rd_data and rd_err stay stable until
   // that edge, and rd_rdy has no effect while rd_valid is low.
   modport slave (
      input  rd_req, rd_addr, bl, blb, rd_rdy,
      output rd_busy, pre_n, wl, sae, rd_data, rd_err, rd_valid
   );

   modport master (
      output rd_req, rd_addr, bl, blb, rd_rdy,
      input  rd_busy, pre_n, wl, sae, rd_data, rd_err, rd_valid
   );
endinterface

// File: rtl/sram_read_seq.sv
// Read-port sequencer for the 4T SRAM array: precharge, wordline, sense,
// then returns the captured word over a valid/ready handshake.
module sram_read_seq #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int PRECH_CYC = 2,
   parameter int WL_CYC    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_read_seq_if.slave    bus,
   output logic [2:0]        dbg_state
);

   localparam int ROWS    = 2**ADDR_W;
   localparam int CNT_MAX = (PRECH_CYC > WL_CYC) ? PRECH_CYC : WL_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRECH = 3'd1,
      WLON  = 3'd2,
      SENSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                pre_n_q, pre_n_d;
   logic [ROWS-1:0]     wl_q, wl_d;
   logic                sae_q, sae_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                err_q, err_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      valid_d = valid_q;

      case (state_q)
         IDLE: begin
            if (bus.rd_req) begin
               addr_d  = bus.rd_addr;
               cnt_d   = CNT_W'(PRECH_CYC - 1);
               state_d = PRECH;
            end
         end
         PRECH: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(WL_CYC - 1);
               state_d = WLON;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WLON: begin
            if (cnt_q == '0) state_d = SENSE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         SENSE: begin
            // A pair reading equal on both rails never split: flag it.
            data_d  = bus.bl;
            err_d   = |(bus.bl ~^ bus.blb);
            valid_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (valid_q && bus.rd_rdy) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Array controls are decoded from the next state so they leave flops.
      pre_n_d = (state_d != PRECH);
      wl_d    = ((state_d == WLON) || (state_d == SENSE)) ? (ROWS'(1) << addr_d) : '0;
      sae_d   = (state_d == SENSE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         pre_n_q <= 1'b1;
         wl_q    <= '0;
         sae_q   <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         pre_n_q <= pre_n_d;
         wl_q    <= wl_d;
         sae_q   <= sae_d;
         data_q  <= data_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.pre_n    = pre_n_q;
   assign bus.wl       = wl_q;
   assign bus.sae      = sae_q;
   assign bus.rd_data  = data_q;
   assign bus.rd_err   = err_q;
   assign bus.rd_valid = valid_q;
   assign bus.rd_busy  = busy_q;
   assign dbg_state    = state_q;

endmodule
